// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and received-byte signals of the uart receiver
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport slave  (input rx, output data, valid, frame_err, busy);
  modport master (output rx, input data, valid, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 uart receiver, LSB first, centre-of-bit sampling
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  uart_rx_if.slave   bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_sync;
  logic          w_rx_s;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ferr;
  logic          w_tick;
  logic          w_sample_bit;
  logic          w_load;
  logic          w_ferr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], bus.rx};
  end

  assign w_rx_s = r_sync[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Stop is judged at mid-bit, so IDLE is re-entered in time for a gapless next start.
  always_comb begin
    w_state_nxt  = r_state;
    w_tick       = 1'b0;
    w_sample_bit = 1'b0;
    w_load       = 1'b0;
    w_ferr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == HALF_LAST) begin
          w_tick      = 1'b1;
          w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == FULL_LAST) begin
          w_tick       = 1'b1;
          w_sample_bit = 1'b1;
          if (r_idx == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == FULL_LAST) begin
          w_tick = 1'b1;
          if (w_rx_s) begin
            w_load      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (w_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (r_state == S_IDLE || r_state == S_WAIT_IDLE || w_tick) r_cnt <= '0;
      else                                                        r_cnt <= r_cnt + 1'b1;
      if (r_state == S_START)  r_idx <= 3'd0;
      else if (w_sample_bit)   r_idx <= r_idx + 3'd1;
      if (w_sample_bit) r_shift[r_idx] <= w_rx_s;
      if (w_load)       r_data <= r_shift;
      r_valid <= w_load;
      r_ferr  <= w_ferr;
    end
  end

  assign bus.data      = r_data;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_ferr;
  assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver, 8N1, LSB first. It oversamples the asynchronous `rx` line with a per-bit clock counter and recovers one byte per frame. Each good byte is presented on `data` with a single-cycle `valid` strobe. It sits directly upstream of the UART byte buffer: `data` drives the buffer's `byte_in` and `valid` drives its `enable`.

## Interface
- `CLKS_PER_BIT`, default 434: `clk` cycles per bit (50 MHz / 115200). Legal range is ≥ 4; the bench uses 16.
- `clk` input 1: single system clock; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `rx` input 1: serial line, asynchronous to `clk`, idles high.
- `data` output 8: last correctly framed byte; holds until the next good frame.
- `valid` output 1: one-cycle pulse when `data` is updated.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `busy` output 1: high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer, reset to 1. All decisions use the synchronized value, `rx_s`.
- Bit counter: width `$clog2(CLKS_PER_BIT)`, reloaded at each sample point. Bit index: 3 bits.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: stay while `rx_s`=1. `rx_s`=0 → START and clear the counter.
  - START: after `CLKS_PER_BIT/2` cycles (integer division), sample `rx_s`. If 0 → DATA with index 0. If 1 → IDLE (glitch or false start; no output).
  - DATA: every `CLKS_PER_BIT` cycles, sample `rx_s` into shift register bit [index]. After index 7 → STOP.
  - STOP: after `CLKS_PER_BIT` cycles, sample `rx_s`.
    - If 1: load `data` from the shift register, pulse `valid`, go to IDLE.
    - If 0: pulse `frame_err`, leave `data` unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s`=1, then → IDLE. This prevents a break (line held low) from being re-read as new start bits.
- The FSM returns to IDLE at mid-stop-bit, so back-to-back frames with no idle gap are received without loss.
- `valid` and `frame_err` are never high in the same cycle.
- `rx` activity in the middle of a bit is ignored; only sample points matter. There is no majority vote.
- No backpressure: the downstream stage must accept `data` on the `valid` cycle.

## Timing
- Reset values (asynchronous, on `reset`=0):
  - state IDLE; counters 0; shift register 0.
  - `data`=8'h00, `valid`=0, `frame_err`=0, `busy`=0.
  - synchronizer flops = 1.
- Reset asserted mid-frame aborts the frame immediately with no `valid` or `frame_err`. After release, the block waits for a fresh falling edge.
- Reference point: t0 is the first cycle in which `rx_s`=0 while in IDLE. This is 2 cycles after the `rx` pin falls.
- Sample schedule, with H = `CLKS_PER_BIT/2` and N = `CLKS_PER_BIT`:
  - start bit sampled at t0+H;
  - data bit i sampled at t0+H+(i+1)·N;
  - stop bit sampled at t0+H+9·N.
- `valid`/`frame_err` is high in the cycle after the stop sample, and `data` changes in that same cycle.
- Worked case, N=16: stop sample at t0+152; `valid` at t0+153.
- `busy` goes high at t0+1 (registered) and drops in the cycle the FSM re-enters IDLE.

## Test plan
- Reset mid-frame: drive 0x55, assert `reset` low during bit 4, release, then send 0x3C → no pulse for the aborted frame; exactly one `valid` with `data`=0x3C. All outputs read their reset values while `reset`=0.
- Single frame, N=16: send 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop) → one `valid` pulse at t0+153, `data`=0xA5, `frame_err` stays 0, `busy` high from t0+1 to the return to IDLE.
- Back-to-back: send 0x00, 0xFF, 0x81 with no idle gap → three `valid` pulses, exactly 160 cycles apart, `data` = 0x00, 0xFF, 0x81 in order.
- False start: pull `rx` low for 5 cycles, then high → no `valid`, no `frame_err`; FSM back in IDLE by t0+9; `busy` low afterwards.
- Framing error and break:
  - send 0x5A with stop bit 0 → `frame_err` pulse at t0+153, `data` keeps its previous value;
  - hold `rx` low for 40 further bit times → no further pulses;
  - return `rx` high, then send 0x12 → `valid` with `data`=0x12.
